instr_encoder: RTL
==================

# instr_encoder

Sequential MIPS instruction encoder and program loader: the inverse of the pipeline's instruction decoder. Accepts decoded instruction fields (format, op type, register addresses, shift amount, immediate/target) over a valid/ready handshake and packs them into 32-bit MIPS words. Buffers the packed words in a small FIFO and streams them into instruction memory at consecutive word addresses. Used by the test/boot path to build programs in-system.

## Interface
- FIFO_DEPTH, 4: encoded-word buffer depth, power of two, ≥2
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- w_start  in  1  begin a load session; sampled in IDLE only
- w_base_addr_32  in  32  first write address, latched on w_start
- w_in_valid  in  1  field bundle valid
- w_in_ready  out  1  encoder can accept a bundle
- w_fmt_2  in  2  format: 0 R, 1 I, 2 J, 3 REGIMM
- w_op_type_6  in  6  funct (R), opcode (I/J), {1'b0,rt-code} (REGIMM)
- w_rs_addr_5, w_rt_addr_5, w_rd_addr_5, w_sh_amt_5  in  5 each  register fields / shift amount
- w_imm_val_16  in  16  immediate / branch offset
- w_target_26  in  26  jump target
- w_end  in  1  end of program
- w_mem_write  out  1  memory write request
- w_mem_addr_32  out  32  write address
- w_mem_data_32  out  32  encoded instruction
- w_mem_ack  in  1  memory accepted current write
- w_done  out  1  one-cycle pulse, session complete
- w_illegal  out  1  one-cycle pulse, bundle rejected
- w_count_16  out  16  words written this session

## Operation
- Encoding: R = {6'h00, rs, rt, rd, sh, op}; I = {op, rs, rt, imm}; J = {op, target}; REGIMM = {6'h01, rs, op[4:0], imm}. Unused fields are ignored.
- States:
  - IDLE: w_in_ready=0. On w_start → RUN; addr←w_base_addr_32, count←0.
  - RUN: a bundle is accepted when valid&ready. w_end → DRAIN; a bundle handshaking in the same cycle is still accepted.
  - DRAIN: w_in_ready=0. FIFO empty and no write pending → DONE.
  - DONE: w_done=1 for one cycle → IDLE.
- w_start outside IDLE is ignored.
- Memory side (RUN/DRAIN): w_mem_write=1 whenever the FIFO is non-empty. Addr/data are held stable until w_mem_ack=1. On ack: pop, addr+=4 (wraps mod 2^32), count+=1 (saturates at 16'hFFFF).
- w_in_ready = RUN & !full. It is derived from registered state only, with no combinational path from w_mem_ack. A pop and a push in the same cycle are allowed when not full.
- Reset values: w_in_ready 0, w_mem_write 0, w_mem_addr_32 0, w_mem_data_32 0, w_done 0, w_illegal 0, w_count_16 0, state IDLE, FIFO empty.
- Reset mid-session discards all buffered words; no write is asserted after reset.

## Timing
- An accepted bundle appears on w_mem_data_32 no earlier than the next cycle (registered FIFO output).
- Throughput is one word per cycle while ack is held high.
- w_done asserts exactly one cycle after the last ack when w_end preceded it. If w_end arrives with the FIFO empty, the path is DRAIN then DONE: w_done two cycles after w_end.
- w_illegal pulses the cycle after the rejected handshake.

## Configuration
- ENC_CHECK_EN defined:
  - Legal sets are: R funct ∈ {ADD, ADDU, SUB, SUBU, MULT, MULTU, DIV, DIVU, SLT, SLTU, SLL, SRL, SRA, SLLV, SRLV, SRAV, JR, JALR}; I ∈ {ADDIU, SLTI, SLTIU, ORI, XORI, LW, SW, LUI, LB, LBU, SB, BEQ, BNE, BGTZ, BLEZ}; J ∈ {J, JAL}; REGIMM ∈ {BGEZ, BLTZ}.
  - A format/op mismatch is illegal.
  - An illegal bundle completes its handshake, is not pushed, and pulses w_illegal. Count and address are unchanged.
- ENC_CHECK_EN undefined: every accepted bundle is encoded verbatim; w_illegal is tied 0.

## Structure
- Opcode, funct and REGIMM constants come from the shared ISA codes include.
- Add to the same include: format codes FMT_R/FMT_I/FMT_J/FMT_REGIMM and state encodings ENC_IDLE/ENC_RUN/ENC_DRAIN/ENC_DONE.
- One sub-module: instr_enc_fifo (synchronous FIFO, FIFO_DEPTH × 32, full/empty flags, same clock/reset).
- The encode mux and legality check stay in the top level.

## Test plan
- Start base 32'h0040_0000, R ADDU rs=1 rt=2 rd=3 sh=0 → one write addr 32'h0040_0000 data 32'h0022_1821, count=1.
- I ADDIU rs=0 rt=8 imm=16'h0005 then J target 26'h010_0000 → data 32'h2408_0005 @+0, 32'h0810_0000 @+4.
- REGIMM BGEZ (op=6'h01) rs=4 imm=16'hFFFF → data 32'h0481_FFFF.
- Hold w_mem_ack=0, offer 5 bundles → w_in_ready drops after 4. Then ack continuously → 5 words in order at base+0..+16, count=5, w_done one cycle after last ack following w_end.
- R funct 6'h3F: with ENC_CHECK_EN → w_illegal pulse, no write, count unchanged. Without it → data 32'h0000_003F written.
- Assert reset with 3 words buffered → w_mem_write=0, count=0, IDLE immediately. No writes until the next w_start.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
// -----------------------------------------------------------------------------
// instr_encoder_pkg
// Shared MIPS ISA codes used by the instruction encoder. It holds the opcode,
// funct and REGIMM rt-code constants, the field-bundle format codes and the
// encoder session state encodings.
// -----------------------------------------------------------------------------
package instr_encoder_pkg;

  // Field-bundle format codes (w_fmt_2)
  localparam logic [1:0] FMT_R      = 2'd0;
  localparam logic [1:0] FMT_I      = 2'd1;
  localparam logic [1:0] FMT_J      = 2'd2;
  localparam logic [1:0] FMT_REGIMM = 2'd3;

  // Encoder session states
  localparam logic [1:0] ENC_IDLE  = 2'd0;
  localparam logic [1:0] ENC_RUN   = 2'd1;
  localparam logic [1:0] ENC_DRAIN = 2'd2;
  localparam logic [1:0] ENC_DONE  = 2'd3;

  // Primary opcodes
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SW      = 6'h2B;

  // SPECIAL funct codes
  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_SLLV  = 6'h04;
  localparam logic [5:0] F_SRLV  = 6'h06;
  localparam logic [5:0] F_SRAV  = 6'h07;
  localparam logic [5:0] F_JR    = 6'h08;
  localparam logic [5:0] F_JALR  = 6'h09;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;

  // REGIMM rt codes, carried as {1'b0, rt} in the op field
  localparam logic [5:0] RT_BLTZ = 6'h00;
  localparam logic [5:0] RT_BGEZ = 6'h01;

endpackage

// File: rtl/instr_enc_fifo.sv
// -----------------------------------------------------------------------------
// instr_enc_fifo
// Synchronous FIFO buffering encoded instruction words between the encoder
// and the instruction-memory write port.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   push, push_data   write a word (ignored when full)
//   pop               drop the head word (ignored when empty)
//   rd_data           head word, valid while !empty
//   full, empty       occupancy flags
//   one_left          exactly one word stored
// -----------------------------------------------------------------------------
module instr_enc_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic             one_left
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      level;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // NOTE: storage has no reset; only pointers and level need it, and the
  // consumer masks rd_data while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  assign rd_data  = mem[rd_ptr];
  assign full     = (level == (AW+1)'(DEPTH));
  assign empty    = (level == '0);
  assign one_left = (level == (AW+1)'(1));

endmodule

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
// Packs decoded MIPS instruction fields into 32-bit words and streams them
// into instruction memory at consecutive word addresses (program loader).
// Optional macro: ENC_CHECK_EN enables the format/op legality check; illegal
// bundles are handshaken, dropped and flagged on w_illegal.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   w_start, w_base_addr_32    begin a session at a base address (IDLE only)
//   w_in_valid / w_in_ready    field-bundle handshake
//   w_fmt_2 .. w_target_26     decoded instruction fields
//   w_end                      last bundle of the program
//   w_mem_write/addr/data/ack  instruction-memory write port
//   w_done                     one-cycle session-complete pulse
//   w_illegal                  one-cycle rejected-bundle pulse
//   w_count_16                 words written this session (saturating)
// -----------------------------------------------------------------------------
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        w_start,
  input  logic [31:0] w_base_addr_32,
  input  logic        w_in_valid,
  output logic        w_in_ready,
  input  logic [1:0]  w_fmt_2,
  input  logic [5:0]  w_op_type_6,
  input  logic [4:0]  w_rs_addr_5,
  input  logic [4:0]  w_rt_addr_5,
  input  logic [4:0]  w_rd_addr_5,
  input  logic [4:0]  w_sh_amt_5,
  input  logic [15:0] w_imm_val_16,
  input  logic [25:0] w_target_26,
  input  logic        w_end,
  output logic        w_mem_write,
  output logic [31:0] w_mem_addr_32,
  output logic [31:0] w_mem_data_32,
  input  logic        w_mem_ack,
  output logic        w_done,
  output logic        w_illegal,
  output logic [15:0] w_count_16
);

  function automatic logic [31:0] encode(
    input logic [1:0]  fmt,
    input logic [5:0]  op,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [4:0]  sh,
    input logic [15:0] imm,
    input logic [25:0] tgt
  );
    case (fmt)
      FMT_R:   return {OP_SPECIAL, rs, rt, rd, sh, op};
      FMT_I:   return {op, rs, rt, imm};
      FMT_J:   return {op, tgt};
      default: return {OP_REGIMM, rs, op[4:0], imm};
    endcase
  endfunction

  logic [1:0]  state;
  logic [1:0]  state_next;
  logic [31:0] addr;
  logic [15:0] count;
  logic [31:0] fifo_data;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_one_left;
  logic        handshake;
  logic        legal;
  logic        push;
  logic        pop;
  logic        writing;

`ifdef ENC_CHECK_EN
  function automatic logic is_legal(input logic [1:0] fmt, input logic [5:0] op);
    case (fmt)
      FMT_R: case (op)
        F_ADD, F_ADDU, F_SUB, F_SUBU, F_MULT, F_MULTU, F_DIV, F_DIVU,
        F_SLT, F_SLTU, F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV,
        F_JR, F_JALR: return 1'b1;
        default:      return 1'b0;
      endcase
      FMT_I: case (op)
        OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ORI, OP_XORI, OP_LW, OP_SW, OP_LUI,
        OP_LB, OP_LBU, OP_SB, OP_BEQ, OP_BNE, OP_BGTZ, OP_BLEZ: return 1'b1;
        default: return 1'b0;
      endcase
      FMT_J:   return (op == OP_J) || (op == OP_JAL);
      default: return (op == RT_BGEZ) || (op == RT_BLTZ);
    endcase
  endfunction

  logic illegal_q;

  assign legal = is_legal(w_fmt_2, w_op_type_6);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal_q <= 1'b0;
    else        illegal_q <= handshake & ~legal;
  end

  assign w_illegal = illegal_q;
`else
  assign legal     = 1'b1;
  assign w_illegal = 1'b0;
`endif

  // Ready depends only on registered state and the FIFO level register, so
  // there is no combinational path from w_mem_ack back to the producer.
  assign w_in_ready = (state == ENC_RUN) & ~fifo_full;
  assign handshake  = w_in_valid & w_in_ready;
  assign push       = handshake & legal;
  assign writing    = ((state == ENC_RUN) || (state == ENC_DRAIN)) & ~fifo_empty;
  assign pop        = writing & w_mem_ack;

  instr_enc_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (encode(w_fmt_2, w_op_type_6, w_rs_addr_5, w_rt_addr_5,
                       w_rd_addr_5, w_sh_amt_5, w_imm_val_16, w_target_26)),
    .pop       (pop),
    .rd_data   (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .one_left  (fifo_one_left)
  );

  // NOTE: default assignment first so no path through the case infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      ENC_IDLE:  if (w_start) state_next = ENC_RUN;
      ENC_RUN:   if (w_end) state_next = ENC_DRAIN;
      // Leave DRAIN on the edge of the final pop so w_done lands one cycle
      // after the last ack.
      ENC_DRAIN: if (fifo_empty || (fifo_one_left && pop)) state_next = ENC_DONE;
      default:   state_next = ENC_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ENC_IDLE;
      addr  <= '0;
      count <= '0;
    end else begin
      state <= state_next;
      if ((state == ENC_IDLE) && w_start) begin
        addr  <= w_base_addr_32;
        count <= '0;
      end else if (pop) begin
        addr  <= addr + 32'd4;
        count <= (count == 16'hFFFF) ? count : count + 16'd1;
      end
    end
  end

  assign w_mem_write   = writing;
  assign w_mem_addr_32 = addr;
  // Mask the un-reset FIFO storage so the data port reads 0 when idle.
  assign w_mem_data_32 = fifo_empty ? 32'h0 : fifo_data;
  assign w_count_16    = count;
  assign w_done        = (state == ENC_DONE);

endmodule
